hilo_ctrl: RTL

HILO_CTRL -- requirements
Module: hilo_ctrl

---
 rtl/hilo_ctrl_if.sv | 44 ++++
 rtl/hilo_ctrl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/hilo_ctrl_if.sv
// hilo_ctrl_if -- bundle of every non-clock signal of the HI/LO controller.
//
// Handshake (valid/ready): an operation is transferred on a rising edge where
// op_valid and op_ready are both high. The pipeline keeps op_code/op_a/op_b
// stable while op_valid is high and op_ready is low (stall = op_valid & ~op_ready).
// flush cancels the op being presented and any mul/div in flight.
//
// Modports:
//   master : pipeline plus mul/div unit (drives op_*, flush, dmu_hi/dmu_lo)
//   slave  : hilo_ctrl (drives op_ready, stall, rdata*, hi/lo, dmu request, dbg_state)
interface hilo_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             op_valid;
  logic [2:0]       op_code;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             flush;
  logic             op_ready;
  logic             stall;
  logic [WIDTH-1:0] rdata;
  logic             rdata_valid;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [3:0]       dmu_m;
  logic [WIDTH-1:0] dmu_a;
  logic [WIDTH-1:0] dmu_b;
  logic [1:0]       dmu_div_begin;
  logic [WIDTH-1:0] dmu_hi;
  logic [WIDTH-1:0] dmu_lo;
  logic             dbg_state;   // 0 = IDLE, 1 = BUSY

  modport master (
    output op_valid, op_code, op_a, op_b, flush, dmu_hi, dmu_lo,
    input  op_ready, stall, rdata, rdata_valid, hi, lo,
           dmu_m, dmu_a, dmu_b, dmu_div_begin, dbg_state
  );

  modport slave (
    input  op_valid, op_code, op_a, op_b, flush, dmu_hi, dmu_lo,
    output op_ready, stall, rdata, rdata_valid, hi, lo,
           dmu_m, dmu_a, dmu_b, dmu_div_begin, dbg_state
  );
endinterface

// File: rtl/hilo_ctrl.sv
// hilo_ctrl -- MIPS-style HI/LO register controller in front of a fixed-latency
// multiply/divide unit (DMU).
//
// Ports:
//   clk    : single clock, all state on the rising edge
//   resetn : asynchronous, active-low reset
//   bus    : hilo_ctrl_if.slave -- op handshake, flush, MFHI/MFLO read data,
//            architectural hi/lo, DMU request (dmu_m/dmu_a/dmu_b/dmu_div_begin),
//            DMU result (dmu_hi/dmu_lo) and dbg_state (FSM state).
//
// Op codes: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO,
//           110 MFHI, 111 MFLO.
//
// Build option: HILO_FWD_EN -- when defined, MFHI/MFLO is accepted in the
// capture cycle and reads the DMU result directly; when undefined it stalls
// through the capture cycle and reads hi/lo on the next cycle.
module hilo_ctrl #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 32
) (
  input  logic       clk,
  input  logic       resetn,
  hilo_ctrl_if.slave bus
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  logic [0:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [3:0]       r_dmu_m;
  logic [WIDTH-1:0] r_dmu_a;
  logic [WIDTH-1:0] r_dmu_b;
  logic [1:0]       r_div_begin;

  logic             w_is_muldiv;
  logic             w_is_mt;
  logic             w_is_mf;
  logic             w_cnt_zero;
  logic             w_capture;
  logic             w_op_ready;
  logic             w_accept;
  logic [WIDTH-1:0] w_rdata;
  logic [3:0]       w_dmu_m_next;
  logic [1:0]       w_div_begin_next;
  logic [CNT_W-1:0] w_cnt_load;

  assign w_is_muldiv = ~bus.op_code[2];
  assign w_is_mt     = (bus.op_code[2:1] == 2'b10);
  assign w_is_mf     = (bus.op_code[2:1] == 2'b11);
  assign w_cnt_zero  = (r_cnt == '0);

  // Last BUSY cycle: the DMU result is valid now; flush overrides it.
  assign w_capture   = (r_state == ST_BUSY) & w_cnt_zero & ~bus.flush;

  // op_ready is forced high during reset so the pipeline sees an idle unit.
  always_comb begin
    w_op_ready = 1'b0;
    if (!resetn) begin
      w_op_ready = 1'b1;
    end else if (r_state == ST_IDLE) begin
      w_op_ready = ~bus.flush;
    end else begin
`ifdef HILO_FWD_EN
      w_op_ready = w_capture & w_is_mf;
`else
      w_op_ready = 1'b0;
`endif
    end
  end

  assign w_accept = bus.op_valid & w_op_ready & resetn;

  // MFHI/MFLO read data: op_code[0] selects LO.
  always_comb begin
    w_rdata = '0;
    if (w_accept & w_is_mf) begin
`ifdef HILO_FWD_EN
      if (r_state == ST_BUSY) begin
        w_rdata = bus.op_code[0] ? bus.dmu_lo : bus.dmu_hi;
      end else begin
        w_rdata = bus.op_code[0] ? r_lo : r_hi;
      end
`else
      w_rdata = bus.op_code[0] ? r_lo : r_hi;
`endif
    end
  end

  // DMU mode encoding for MULT/MULTU/DIV/DIVU.
  always_comb begin
    w_dmu_m_next = 4'b0000;
    case (bus.op_code[1:0])
      2'b00:   w_dmu_m_next = 4'b0101;
      2'b01:   w_dmu_m_next = 4'b0110;
      2'b10:   w_dmu_m_next = 4'b1011;
      default: w_dmu_m_next = 4'b0111;
    endcase
  end

  assign w_div_begin_next = bus.op_code[1] ? (bus.op_code[0] ? 2'd2 : 2'd1) : 2'd0;
  assign w_cnt_load       = bus.op_code[1] ? CNT_W'(DIV_LAT - 1) : CNT_W'(MUL_LAT - 1);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_dmu_m     <= 4'b0000;
      r_dmu_a     <= '0;
      r_dmu_b     <= '0;
      r_div_begin <= 2'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (w_is_muldiv) begin
              r_dmu_a     <= bus.op_a;
              r_dmu_b     <= bus.op_b;
              r_dmu_m     <= w_dmu_m_next;
              r_div_begin <= w_div_begin_next;
              r_cnt       <= w_cnt_load;
              r_state     <= ST_BUSY;
            end else if (w_is_mt) begin
              if (bus.op_code[0]) begin
                r_lo <= bus.op_a;
              end else begin
                r_hi <= bus.op_a;
              end
            end
          end
        end
        default: begin
          // div_begin is a one-cycle pulse on the first BUSY cycle.
          r_div_begin <= 2'd0;
          if (bus.flush) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_dmu_m <= 4'b0000;
          end else if (w_capture) begin
            r_hi    <= bus.dmu_hi;
            r_lo    <= bus.dmu_lo;
            r_dmu_m <= 4'b0000;
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
      endcase
    end
  end

  assign bus.op_ready      = w_op_ready;
  assign bus.stall         = bus.op_valid & ~w_op_ready;
  assign bus.rdata         = w_rdata;
  assign bus.rdata_valid   = w_accept & w_is_mf;
  assign bus.hi            = r_hi;
  assign bus.lo            = r_lo;
  assign bus.dmu_m         = r_dmu_m;
  assign bus.dmu_a         = r_dmu_a;
  assign bus.dmu_b         = r_dmu_b;
  assign bus.dmu_div_begin = r_div_begin;
  assign bus.dbg_state     = r_state;

endmodule
